// File: rtl/exception_unit.sv
// Exception entry sequencer for the multicycle CPU: captures EPC and cause, fetches the
// handler vector byte through the memory address override, then strobes the PC load.
module exception_unit #(
    parameter logic [31:0] VEC_OPCODE   = 32'd253,
    parameter logic [31:0] VEC_OVERFLOW = 32'd254,
    parameter logic [31:0] VEC_DIVZERO  = 32'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_divzero,
    input  logic [31:0] pc_in,
    output logic [31:0] epc_out,
    output logic [31:0] exc_addr,
    output logic        exc_mem_sel,
    output logic        exc_pcsrc_force,
    output logic        exc_pc_write,
    output logic [1:0]  exc_cause,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_LOAD,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [31:0] r_epc;
    logic [31:0] r_addr;
    logic [1:0]  r_cause;
    logic        r_mem_sel;
    logic        r_pcsrc_force;
    logic        r_pc_write;
    logic        r_busy;

    logic        w_any_exc;
    logic [1:0]  w_cause;
    logic [31:0] w_vec;

    assign w_any_exc = exc_opcode | exc_overflow | exc_divzero;

    // Fixed priority when several causes arrive together: opcode > overflow > divzero.
    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred.
        w_cause = 2'd0;
        w_vec   = '0;
        if (exc_opcode) begin
            w_cause = 2'd1;
            w_vec   = VEC_OPCODE;
        end else if (exc_overflow) begin
            w_cause = 2'd2;
            w_vec   = VEC_OVERFLOW;
        end else if (exc_divzero) begin
            w_cause = 2'd3;
            w_vec   = VEC_DIVZERO;
        end
    end

    // Strobes are registered alongside the state so no exception input reaches an output
    // combinationally; each transition sets the strobes for the state being entered.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state       <= S_IDLE;
            r_epc         <= '0;
            r_addr        <= '0;
            r_cause       <= 2'd0;
            r_mem_sel     <= 1'b0;
            r_pcsrc_force <= 1'b0;
            r_pc_write    <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_exc) begin
                        r_state   <= S_REQ;
                        r_epc     <= pc_in - 32'd4;
                        r_cause   <= w_cause;
                        r_addr    <= w_vec;
                        r_mem_sel <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                S_REQ: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_state       <= S_LOAD;
                    r_mem_sel     <= 1'b0;
                    r_pcsrc_force <= 1'b1;
                    r_pc_write    <= 1'b1;
                end
                S_LOAD: begin
                    r_state       <= S_DONE;
                    r_pcsrc_force <= 1'b0;
                    r_pc_write    <= 1'b0;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_mem_sel     <= 1'b0;
                    r_pcsrc_force <= 1'b0;
                    r_pc_write    <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    assign epc_out         = r_epc;
    assign exc_addr        = r_addr;
    assign exc_cause       = r_cause;
    assign exc_mem_sel     = r_mem_sel;
    assign exc_pcsrc_force = r_pcsrc_force;
    assign exc_pc_write    = r_pc_write;
    assign busy            = r_busy;

endmodule
